max_window_ctrl: RTL and testbench

Measurement-window sequencer around one internal max_counter instance (WIDTH bits, occupancy tracker). It converts per-cycle inc/dec events into counter commands and runs fixed-length windows. At each window end it snapshots the window's peak occupancy into a single-entry valid/ready output buffer, then clears the maximum. Used beside FIFOs and credit pools to report per-window high-water marks to a CSR or trace sink.

---
 rtl/max_window_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_max_window_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_window_ctrl.sv
// max_window_ctrl: measurement-window sequencer around a max_counter.
// Maps per-cycle inc/dec events onto counter commands and runs windows of
// fixed length. At each window end it snapshots the peak occupancy into a
// single-entry valid/ready buffer, then clears the running maximum.
// Optional feature: define MAX_WINDOW_CTRL_INDEX_EN to add sample_idx_o,
// which carries the index of the sampled window.

// Occupancy counter that also tracks the running maximum and a sticky
// overflow flag. max_o lags q_o by one cycle, so the true peak is
// max(q_o, max_o).
module max_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             clear_max_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] delta_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] max_o,
    output logic             overflow_o
);
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    // Next count, running maximum and sticky overflow.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
        q_d   = q_q;
        max_d = max_q;
        ovf_d = ovf_q;
        sum   = {1'b0, q_q} + {1'b0, delta_i};
        if (q_q > max_q) begin
            max_d = q_q;
        end
        if (clear_max_i) begin
            max_d = '0;
        end
        if (clear_i) begin
            q_d   = '0;
            max_d = '0;
            ovf_d = 1'b0;
        end else if (load_i) begin
            q_d = d_i;
        end else if (en_i) begin
            if (down_i) begin
                q_d = q_q - delta_i;
            end else begin
                q_d = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: flops use non-blocking <=; blocking = stays inside always_comb.
        if (!rst_ni) begin
            q_q   <= '0;
            max_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            max_q <= max_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o        = q_q;
    assign max_o      = max_q;
    assign overflow_o = ovf_q;
endmodule

module max_window_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TIMER_WIDTH = 16
`ifdef MAX_WINDOW_CTRL_INDEX_EN
    ,
    parameter int IDX_WIDTH   = 8
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_clear,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [TIMER_WIDTH-1:0] cfg_window_i,
    input  logic                   inc_i,
    input  logic                   dec_i,
    output logic                   busy_o,
    output logic [WIDTH-1:0]       occ_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [WIDTH-1:0]       sample_max_o,
    output logic                   sample_ovf_o,
    output logic                   sample_partial_o,
    output logic                   sample_lost_o,
    output logic                   underflow_o
`ifdef MAX_WINDOW_CTRL_INDEX_EN
    ,
    output logic [IDX_WIDTH-1:0]   sample_idx_o
`endif
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Control strobes decoded from state and inputs.
    logic start_acc, window_end, snapshot, snap_partial, uf_hit;
    logic cnt_clear, cnt_clear_max, cnt_en, cnt_down;

    // Counter outputs.
    logic [WIDTH-1:0] cnt_q, cnt_max;
    logic             cnt_ovf;

    // Window timing and sticky underflow.
    logic [TIMER_WIDTH-1:0] win_q, win_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   underflow_q, underflow_d;

    // Single-entry sample buffer.
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] smax_q, smax_d;
    logic             sovf_q, sovf_d;
    logic             spart_q, spart_d;
    logic             slost_q, slost_d;

`ifdef MAX_WINDOW_CTRL_INDEX_EN
    logic [IDX_WIDTH-1:0] widx_q, widx_d;
    logic [IDX_WIDTH-1:0] sidx_q, sidx_d;
`endif

    max_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (cnt_clear),
        .clear_max_i (cnt_clear_max),
        .en_i        (cnt_en),
        .load_i      (1'b0),
        .down_i      (cnt_down),
        .delta_i     (WIDTH'(1)),
        .d_i         ('0),
        .q_o         (cnt_q),
        .max_o       (cnt_max),
        .overflow_o  (cnt_ovf)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start wins in IDLE, stop ends RUN; fence clear overrides.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (stop_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reg_clear) begin
            state_d = IDLE;
        end
    end

    // FSM outputs: counter commands, window end and snapshot strobes.
    always_comb begin
        start_acc    = 1'b0;
        window_end   = 1'b0;
        snapshot     = 1'b0;
        snap_partial = 1'b0;
        uf_hit       = 1'b0;
        cnt_en       = 1'b0;
        cnt_down     = 1'b0;
        case (state_q)
            IDLE: start_acc = start_i;
            RUN: begin
                window_end   = (timer_q == '0);
                snapshot     = window_end | stop_i;
                // A stop landing on the window end counts as a full window.
                snap_partial = stop_i & ~window_end;
                uf_hit       = dec_i & ~inc_i & (cnt_q == '0);
                cnt_en       = (inc_i ^ dec_i) & ~uf_hit;
                cnt_down     = dec_i;
            end
            default: ;
        endcase
        cnt_clear     = reg_clear | start_acc;
        cnt_clear_max = start_acc | window_end;
    end

    // Next values for the timer, underflow flag and sample buffer.
    always_comb begin
        win_d       = win_q;
        timer_d     = timer_q;
        underflow_d = underflow_q;
        valid_d     = valid_q;
        smax_d      = smax_q;
        sovf_d      = sovf_q;
        spart_d     = spart_q;
        slost_d     = slost_q;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
        widx_d      = widx_q;
        sidx_d      = sidx_q;
`endif
        if (reg_clear) begin
            win_d       = '0;
            timer_d     = '0;
            underflow_d = 1'b0;
            valid_d     = 1'b0;
            smax_d      = '0;
            sovf_d      = 1'b0;
            spart_d     = 1'b0;
            slost_d     = 1'b0;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
            widx_d      = '0;
            sidx_d      = '0;
`endif
        end else begin
            if (start_acc) begin
                // A zero-length request still gives one-cycle windows.
                win_d       = (cfg_window_i == '0) ? TIMER_WIDTH'(1) : cfg_window_i;
                timer_d     = win_d - TIMER_WIDTH'(1);
                underflow_d = 1'b0;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
                widx_d      = '0;
`endif
            end else if (state_q == RUN) begin
                timer_d = window_end ? (win_q - TIMER_WIDTH'(1)) : (timer_q - TIMER_WIDTH'(1));
                if (uf_hit) begin
                    underflow_d = 1'b1;
                end
            end

            if (snapshot) begin
                // Overwriting an unconsumed sample flags the loss in the new one.
                valid_d = 1'b1;
                smax_d  = (cnt_q > cnt_max) ? cnt_q : cnt_max;
                sovf_d  = cnt_ovf;
                spart_d = snap_partial;
                slost_d = valid_q & ~sample_ready_i;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
                sidx_d  = widx_q;
                widx_d  = widx_q + IDX_WIDTH'(1);
`endif
            end else if (valid_q && sample_ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    // Timer, underflow and sample buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q       <= '0;
            timer_q     <= '0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
            smax_q      <= '0;
            sovf_q      <= 1'b0;
            spart_q     <= 1'b0;
            slost_q     <= 1'b0;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
            widx_q      <= '0;
            sidx_q      <= '0;
`endif
        end else begin
            win_q       <= win_d;
            timer_q     <= timer_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
            smax_q      <= smax_d;
            sovf_q      <= sovf_d;
            spart_q     <= spart_d;
            slost_q     <= slost_d;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
            widx_q      <= widx_d;
            sidx_q      <= sidx_d;
`endif
        end
    end

    assign busy_o           = (state_q == RUN);
    assign occ_o            = cnt_q;
    assign sample_valid_o   = valid_q;
    assign sample_max_o     = smax_q;
    assign sample_ovf_o     = sovf_q;
    assign sample_partial_o = spart_q;
    assign sample_lost_o    = slost_q;
    assign underflow_o      = underflow_q;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
    assign sample_idx_o     = sidx_q;
`endif
endmodule

// File: tb/tb_max_window_ctrl.sv
// Testbench for max_window_ctrl (WIDTH=4 so wrap-around is reachable quickly).
// A behavioural model built from window positions and a per-window queue of
// occupancy values is compared against the DUT on every cycle, plus
// hand-computed literal checks for the directed scenarios.
module tb_max_window_ctrl;
    localparam int WIDTH = 4;
    localparam int TW    = 16;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            reg_clear = 1'b0;
    logic            start_i = 1'b0;
    logic            stop_i = 1'b0;
    logic [TW-1:0]   cfg_window_i = '0;
    logic            inc_i = 1'b0;
    logic            dec_i = 1'b0;
    logic            sample_ready_i = 1'b1;
    logic            busy_o;
    logic [WIDTH-1:0] occ_o;
    logic            sample_valid_o;
    logic [WIDTH-1:0] sample_max_o;
    logic            sample_ovf_o;
    logic            sample_partial_o;
    logic            sample_lost_o;
    logic            underflow_o;
`ifdef MAX_WINDOW_CTRL_INDEX_EN
    logic [7:0]      sample_idx_o;
`endif

    max_window_ctrl #(.WIDTH(WIDTH), .TIMER_WIDTH(TW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .reg_clear        (reg_clear),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .cfg_window_i     (cfg_window_i),
        .inc_i            (inc_i),
        .dec_i            (dec_i),
        .busy_o           (busy_o),
        .occ_o            (occ_o),
        .sample_valid_o   (sample_valid_o),
        .sample_ready_i   (sample_ready_i),
        .sample_max_o     (sample_max_o),
        .sample_ovf_o     (sample_ovf_o),
        .sample_partial_o (sample_partial_o),
        .sample_lost_o    (sample_lost_o),
        .underflow_o      (underflow_o)
`ifdef MAX_WINDOW_CTRL_INDEX_EN
        ,
        .sample_idx_o     (sample_idx_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit m_run, m_ovf, m_uf;
    int m_occ, m_w, m_pos;
    int m_win[$];                       // occupancy seen in each cycle of the current window
    bit m_bv, m_bovf, m_bpart, m_blost;
    int m_bmax;
    int m_widx, m_bidx;

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        bit wend, snap;
        int peak;
        bit ovf_now;
        if (reg_clear) begin
            m_run = 0; m_ovf = 0; m_uf = 0; m_occ = 0; m_w = 0; m_pos = 0;
            m_win.delete();
            m_bv = 0; m_bovf = 0; m_bpart = 0; m_blost = 0; m_bmax = 0;
            m_widx = 0; m_bidx = 0;
            return;
        end
        if (!m_run) begin
            if (start_i) begin
                m_run = 1; m_w = (cfg_window_i == 0) ? 1 : int'(cfg_window_i);
                m_pos = 0; m_win.delete(); m_occ = 0; m_ovf = 0; m_uf = 0; m_widx = 0;
            end
            if (m_bv && sample_ready_i) m_bv = 0;
            return;
        end
        m_win.push_back(m_occ);
        ovf_now = m_ovf;
        wend = (m_pos == m_w - 1);
        snap = wend || stop_i;
        if (snap) begin
            peak = 0;
            foreach (m_win[k]) if (m_win[k] > peak) peak = m_win[k];
            m_blost = m_bv && !sample_ready_i;
            m_bv = 1; m_bmax = peak; m_bovf = ovf_now; m_bpart = !wend;
            m_bidx = m_widx % 256; m_widx++;
        end else if (m_bv && sample_ready_i) begin
            m_bv = 0;
        end
        if (inc_i && !dec_i) begin
            if (m_occ == MAXV) begin m_occ = 0; m_ovf = 1; end
            else m_occ++;
        end else if (dec_i && !inc_i) begin
            if (m_occ == 0) m_uf = 1;
            else m_occ--;
        end
        if (wend) begin m_pos = 0; m_win.delete(); end
        else m_pos++;
        if (stop_i) m_run = 0;
    endfunction

    // Compare DUT against the model on every falling edge once out of reset.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("busy", busy_o, m_run);
            check("occ", occ_o, m_occ);
            check("valid", sample_valid_o, m_bv);
            check("underflow", underflow_o, m_uf);
            if (m_bv) begin
                check("smax", sample_max_o, m_bmax);
                check("sovf", sample_ovf_o, m_bovf);
                check("spartial", sample_partial_o, m_bpart);
                check("slost", sample_lost_o, m_blost);
`ifdef MAX_WINDOW_CTRL_INDEX_EN
                check("sidx", sample_idx_o, m_bidx);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit s, input bit p, input bit i, input bit d);
        start_i = s; stop_i = p; inc_i = i; dec_i = d;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        start_i = 0; stop_i = 0; inc_i = 0; dec_i = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
    endtask

    task automatic fence();
        reg_clear = 1'b1;
        drive(0, 0, 0, 0);
        reg_clear = 1'b0;
    endtask

    task automatic start_win(input int w);
        cfg_window_i = TW'(w);
        drive(1, 0, 0, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            drive(0, 0, 0, 0);
            n++;
        end while (!sample_valid_o && n < budget);
        check("wait_valid", sample_valid_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_occ", occ_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_uf", underflow_o, 0);
        rst_ni = 1'b1;
        cmp_en = 1'b1;

        // W=4: three incs, then idle
        sample_ready_i = 1'b1;
        start_win(4);
        repeat (3) drive(0, 0, 1, 0);
        wait_valid(10);
        check("t1_max", sample_max_o, 3);
        check("t1_partial", sample_partial_o, 0);
        check("t1_occ", occ_o, 3);
        wait_valid(10);
        check("t1_max2", sample_max_o, 3);
        drive(0, 1, 0, 0);

        // W=10: inc x5, dec x4, then one inc in the next window
        fence();
        start_win(10);
        repeat (5) drive(0, 0, 1, 0);
        repeat (4) drive(0, 0, 0, 1);
        wait_valid(10);
        check("t2_max", sample_max_o, 5);
        check("t2_occ", occ_o, 1);
        drive(0, 0, 1, 0);
        wait_valid(15);
        check("t2_max2", sample_max_o, 2);

        // Back-pressure across two window ends
        fence();
        sample_ready_i = 1'b0;
        start_win(4);
        repeat (2) drive(0, 0, 1, 0);
        idle(2);
        check("t3_max1", sample_max_o, 2);
        repeat (2) drive(0, 0, 1, 0);
        idle(2);
        check("t3_valid", sample_valid_o, 1);
        check("t3_max", sample_max_o, 4);
        check("t3_lost", sample_lost_o, 1);
        sample_ready_i = 1'b1;
        drive(0, 0, 0, 0);
        check("t3_drop", sample_valid_o, 0);

        // Stop mid-window after peak 6
        fence();
        start_win(20);
        repeat (6) drive(0, 0, 1, 0);
        idle(2);
        drive(0, 1, 0, 0);
        check("t4_valid", sample_valid_o, 1);
        check("t4_max", sample_max_o, 6);
        check("t4_partial", sample_partial_o, 1);
        check("t4_busy", busy_o, 0);
        drive(0, 0, 1, 0);
        check("t4_occ_idle", occ_o, 6);

        // Underflow and simultaneous inc+dec
        fence();
        start_win(20);
        drive(0, 0, 0, 1);
        check("t5_occ0", occ_o, 0);
        check("t5_uf", underflow_o, 1);
        repeat (2) drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        check("t5_occ2", occ_o, 2);

        // Wrap at all-ones
        fence();
        start_win(30);
        repeat (16) drive(0, 0, 1, 0);
        check("t6_occ", occ_o, 0);
        wait_valid(40);
        check("t6_max", sample_max_o, 15);
        check("t6_ovf", sample_ovf_o, 1);
`ifdef MAX_WINDOW_CTRL_INDEX_EN
        check("t6_idx0", sample_idx_o, 0);
        wait_valid(40);
        check("t6_idx1", sample_idx_o, 1);
        wait_valid(40);
        check("t6_idx2", sample_idx_o, 2);
`endif

        // Start and stop together in IDLE with zero window length
        fence();
        cfg_window_i = '0;
        drive(1, 1, 0, 0);
        check("t7_busy", busy_o, 1);

        // Randomized traffic
        fence();
        for (int c = 0; c < 3000; c++) begin
            sample_ready_i = ($urandom_range(0, 9) < 7);
            cfg_window_i   = TW'($urandom_range(0, 7));
            reg_clear      = ($urandom_range(0, 499) == 0);
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            reg_clear = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
